// File: rtl/shift_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : shift_arbiter                                                |
// | Description : Two-requester round-robin front end for a shared 32-bit      |
// |               barrel shifter. A request is accepted in IDLE, its operands  |
// |               are presented to the shifter for one cycle in SHIFT, and the |
// |               result is held in HOLD until the consumer takes it.          |
// |               Amounts of 32 or more saturate to 32 and yield zero.         |
// |               Optional macro SHIFT_ARB_BYPASS_EN: a zero amount skips the  |
// |               shifter and returns the operand one cycle earlier.           |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module shift_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  // requester 0 (operand-2 path)
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_data,
  input  logic [31:0] req0_amt,
  input  logic        req0_dir,
  // requester 1 (address path)
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_data,
  input  logic [31:0] req1_amt,
  input  logic        req1_dir,
  // shared shifter
  output logic        sh_enable,
  output logic [31:0] sh_in_data,
  output logic [31:0] sh_shift_amt,
  output logic        sh_control,
  input  logic [31:0] sh_out_data,
  // response
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_data
);

  localparam logic [31:0] c_AMT_SAT = 32'd32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_last_grant;
  logic [31:0] r_data;
  logic [31:0] r_amt;
  logic        r_dir;
  logic        r_id;
  logic        r_force_zero;
  logic [31:0] r_rsp_data;

  logic        w_gnt0;
  logic        w_gnt1;
  logic        w_accept;
  logic [31:0] w_sel_data;
  logic [31:0] w_sel_amt;
  logic        w_sel_dir;
  logic        w_amt_big;

  // Round-robin: under contention the requester not granted last wins.
  assign w_gnt0 = req0_valid & (~req1_valid | r_last_grant);
  assign w_gnt1 = req1_valid & (~req0_valid | ~r_last_grant);

  assign w_sel_data = w_gnt1 ? req1_data : req0_data;
  assign w_sel_amt  = w_gnt1 ? req1_amt  : req0_amt;
  assign w_sel_dir  = w_gnt1 ? req1_dir  : req0_dir;
  assign w_amt_big  = |w_sel_amt[31:5];

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic and acceptance strobe.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_gnt0 | w_gnt1) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_SHIFT;
`ifdef SHIFT_ARB_BYPASS_EN
          if (w_sel_amt == 32'd0) begin
            w_state_nxt = ST_HOLD;
          end
`endif
        end
      end
      ST_SHIFT: begin
        w_state_nxt = ST_HOLD;
      end
      ST_HOLD: begin
        if (rsp_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Operand capture on acceptance and result capture at the end of SHIFT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= 1'b1;
      r_data       <= 32'd0;
      r_amt        <= 32'd0;
      r_dir        <= 1'b0;
      r_id         <= 1'b0;
      r_force_zero <= 1'b0;
      r_rsp_data   <= 32'd0;
    end else begin
      if (w_accept) begin
        r_last_grant <= w_gnt1;
        r_id         <= w_gnt1;
        r_data       <= w_sel_data;
        r_amt        <= w_amt_big ? c_AMT_SAT : w_sel_amt;
        r_dir        <= w_sel_dir;
        r_force_zero <= w_amt_big;
`ifdef SHIFT_ARB_BYPASS_EN
        if (w_sel_amt == 32'd0) begin
          r_rsp_data <= w_sel_data;
        end
`endif
      end else if (r_state == ST_SHIFT) begin
        // Oversized amounts are zeroed here rather than trusting the shifter.
        r_rsp_data <= r_force_zero ? 32'd0 : sh_out_data;
      end
    end
  end

  // Readies are gated by reset so every output reads zero while rst_n is low.
  assign req0_ready   = rst_n & (r_state == ST_IDLE) & w_gnt0;
  assign req1_ready   = rst_n & (r_state == ST_IDLE) & w_gnt1;

  assign sh_enable    = (r_state == ST_SHIFT);
  assign sh_in_data   = r_data;
  assign sh_shift_amt = r_amt;
  assign sh_control   = r_dir;

  assign rsp_valid    = (r_state == ST_HOLD);
  assign rsp_id       = r_id;
  assign rsp_data     = r_rsp_data;

endmodule
`default_nettype wire

// File: tb/tb_shift_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_shift_arbiter                                             |
// | Description : Directed self-checking bench for shift_arbiter, with a       |
// |               behavioural model of the shared shifter.                     |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_shift_arbiter;

  logic        clk;
  logic        rst_n;
  logic        req0_valid, req0_ready, req0_dir;
  logic [31:0] req0_data, req0_amt;
  logic        req1_valid, req1_ready, req1_dir;
  logic [31:0] req1_data, req1_amt;
  logic        sh_enable, sh_control;
  logic [31:0] sh_in_data, sh_shift_amt, sh_out_data;
  logic        rsp_valid, rsp_ready, rsp_id;
  logic [31:0] rsp_data;

  int n_total = 0;
  int n_bad   = 0;

  shift_arbiter u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req0_valid   (req0_valid),
    .req0_ready   (req0_ready),
    .req0_data    (req0_data),
    .req0_amt     (req0_amt),
    .req0_dir     (req0_dir),
    .req1_valid   (req1_valid),
    .req1_ready   (req1_ready),
    .req1_data    (req1_data),
    .req1_amt     (req1_amt),
    .req1_dir     (req1_dir),
    .sh_enable    (sh_enable),
    .sh_in_data   (sh_in_data),
    .sh_shift_amt (sh_shift_amt),
    .sh_control   (sh_control),
    .sh_out_data  (sh_out_data),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_id       (rsp_id),
    .rsp_data     (rsp_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shifter model: poison values when disabled or oversized so a wrong
  // capture or a missing zero-force is visible in rsp_data.
  always_comb begin
    if (!sh_enable)
      sh_out_data = 32'hBAD0_BAD0;
    else if (sh_shift_amt >= 32'd32)
      sh_out_data = 32'hDEAD_BEEF;
    else if (sh_control)
      sh_out_data = sh_in_data >> sh_shift_amt[4:0];
    else
      sh_out_data = sh_in_data << sh_shift_amt[4:0];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic idle_inputs();
    req0_valid = 1'b0; req0_data = 32'd0; req0_amt = 32'd0; req0_dir = 1'b0;
    req1_valid = 1'b0; req1_data = 32'd0; req1_amt = 32'd0; req1_dir = 1'b0;
  endtask

  // Watchdog so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic exp_id;
    idle_inputs();
    rsp_ready = 1'b0;

    // ---- reset state (valid high during reset must not show ready) ----
    rst_n = 1'b0;
    req0_valid = 1'b1;
    #3;
    check("rst_ready0",   {31'd0, req0_ready},   32'd0);
    check("rst_rsp_valid",{31'd0, rsp_valid},    32'd0);
    check("rst_sh_enable",{31'd0, sh_enable},    32'd0);
    check("rst_rsp_data", rsp_data,              32'd0);
    check("rst_sh_amt",   sh_shift_amt,          32'd0);
    req0_valid = 1'b0;
    do_reset();

    // ---- idle with no valids: nothing happens ----
    tick(); tick();
    check("idle_ready0",  {31'd0, req0_ready},   32'd0);
    check("idle_rspv",    {31'd0, rsp_valid},    32'd0);

    // ---- single request: 0xF0 >> 4 ----
    req0_valid = 1'b1; req0_data = 32'h0000_00F0; req0_amt = 32'd4; req0_dir = 1'b1;
    #1;
    check("single_ready0", {31'd0, req0_ready}, 32'd1);
    check("single_ready1", {31'd0, req1_ready}, 32'd0);
    tick();  // accept edge
    idle_inputs();
    check("single_sh_en",   {31'd0, sh_enable},  32'd1);
    check("single_sh_data", sh_in_data,          32'h0000_00F0);
    check("single_sh_amt",  sh_shift_amt,        32'd4);
    check("single_sh_ctl",  {31'd0, sh_control}, 32'd1);
    check("single_rspv_n1", {31'd0, rsp_valid},  32'd0);
    tick();
    check("single_rspv_n2", {31'd0, rsp_valid},  32'd1);
    check("single_data",    rsp_data,            32'h0000_000F);
    check("single_id",      {31'd0, rsp_id},     32'd0);
    check("single_sh_off",  {31'd0, sh_enable},  32'd0);
    check("single_sh_hold", sh_in_data,          32'h0000_00F0);

    // ---- backpressure: 5 cycles with rsp_ready low, both requesters waiting ----
    req0_valid = 1'b1; req0_data = 32'h0000_0001; req0_amt = 32'd1; req0_dir = 1'b0;
    req1_valid = 1'b1; req1_data = 32'h8000_0000; req1_amt = 32'd3; req1_dir = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_rspv",   {31'd0, rsp_valid},  32'd1);
      check("bp_data",   rsp_data,            32'h0000_000F);
      check("bp_id",     {31'd0, rsp_id},     32'd0);
      check("bp_ready0", {31'd0, req0_ready}, 32'd0);
      check("bp_ready1", {31'd0, req1_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("bp_release_rspv", {31'd0, rsp_valid},  32'd0);
    // last grant was 0, so requester 1 wins this contended cycle
    check("bp_next_ready1",  {31'd0, req1_ready}, 32'd1);
    check("bp_next_ready0",  {31'd0, req0_ready}, 32'd0);
    idle_inputs();

    // ---- contention from reset: grants 0,1,0,1 ----
    do_reset();
    req0_valid = 1'b1; req0_data = 32'h0000_0001; req0_amt = 32'd1; req0_dir = 1'b0;
    req1_valid = 1'b1; req1_data = 32'h8000_0000; req1_amt = 32'd3; req1_dir = 1'b1;
    rsp_ready = 1'b1;
    #1;
    for (int g = 0; g < 4; g++) begin
      exp_id = g[0];
      check("cont_ready0", {31'd0, req0_ready}, {31'd0, ~exp_id});
      check("cont_ready1", {31'd0, req1_ready}, {31'd0, exp_id});
      tick();
      check("cont_shift_en", {31'd0, sh_enable}, 32'd1);
      tick();
      check("cont_rspv", {31'd0, rsp_valid}, 32'd1);
      check("cont_id",   {31'd0, rsp_id},    {31'd0, exp_id});
      check("cont_data", rsp_data, exp_id ? 32'h1000_0000 : 32'h0000_0002);
      tick();
    end
    rsp_ready = 1'b0;
    idle_inputs();
    #1;

    // ---- large amount: 40 saturates to 32, result forced to zero ----
    req1_valid = 1'b1; req1_data = 32'hFFFF_FFFF; req1_amt = 32'd40; req1_dir = 1'b0;
    #1;
    check("big_ready1", {31'd0, req1_ready}, 32'd1);
    tick();
    idle_inputs();
    check("big_sh_amt", sh_shift_amt, 32'd32);
    tick();
    check("big_data", rsp_data,         32'd0);
    check("big_id",   {31'd0, rsp_id},  32'd1);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // ---- boundary: amount 31 is a legal shift ----
    req1_valid = 1'b1; req1_data = 32'hFFFF_FFFF; req1_amt = 32'd31; req1_dir = 1'b0;
    tick();
    idle_inputs();
    check("amt31_sh_amt", sh_shift_amt, 32'd31);
    tick();
    check("amt31_data", rsp_data, 32'h8000_0000);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // ---- reset in the middle of SHIFT ----
    req0_valid = 1'b1; req0_data = 32'hCAFE_0000; req0_amt = 32'd8; req0_dir = 1'b1;
    tick();
    idle_inputs();
    check("mid_sh_en", {31'd0, sh_enable}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_rspv",  {31'd0, rsp_valid}, 32'd0);
    check("mid_rst_sh_en", {31'd0, sh_enable}, 32'd0);
    check("mid_rst_sh_in", sh_in_data,         32'd0);
    tick();
    rst_n = 1'b1;
    req0_valid = 1'b1; req0_data = 32'h0000_000F; req0_amt = 32'd2; req0_dir = 1'b0;
    #1;
    check("post_rst_ready0", {31'd0, req0_ready}, 32'd1);
    tick();
    idle_inputs();
    check("post_rst_no_stale", {31'd0, rsp_valid}, 32'd0);
    tick();
    check("post_rst_rspv", {31'd0, rsp_valid}, 32'd1);
    check("post_rst_data", rsp_data,           32'h0000_003C);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // ---- zero amount: bypass if enabled, else through the shifter ----
    req0_valid = 1'b1; req0_data = 32'h1234_5678; req0_amt = 32'd0; req0_dir = 1'b0;
    tick();
    idle_inputs();
`ifdef SHIFT_ARB_BYPASS_EN
    check("byp_rspv_n1", {31'd0, rsp_valid}, 32'd1);
    check("byp_data",    rsp_data,           32'h1234_5678);
    check("byp_sh_en",   {31'd0, sh_enable}, 32'd0);
`else
    check("zero_sh_en",   {31'd0, sh_enable}, 32'd1);
    check("zero_rspv_n1", {31'd0, rsp_valid}, 32'd0);
    tick();
    check("zero_rspv_n2", {31'd0, rsp_valid}, 32'd1);
    check("zero_data",    rsp_data,           32'h1234_5678);
`endif
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("final_idle", {31'd0, rsp_valid}, 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
